// File: rtl/demux_pkg.sv
// Shared constants and types for the 1:8 stream demultiplexer.
package demux_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel.
module demux_slot #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         ready,
  output logic [N-1:0] q,
  output logic         valid
);
  logic [N-1:0] q_q, q_d;
  logic         valid_q, valid_d;

  // A load wins over a delivery, so a word may be replaced without a bubble.
  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    if (load) begin
      q_d     = d;
      valid_d = 1'b1;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign q     = q_q;
  assign valid = valid_q;
endmodule

// File: rtl/demux8_stream.sv
// Registered 1:8 stream demultiplexer with explicit or round-robin destination.
module demux8_stream #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   switch,
  input  logic         auto,
  output logic [N-1:0] out0,
  output logic [N-1:0] out1,
  output logic [N-1:0] out2,
  output logic [N-1:0] out3,
  output logic [N-1:0] out4,
  output logic [N-1:0] out5,
  output logic [N-1:0] out6,
  output logic [N-1:0] out7,
  output logic [7:0]   out_valid,
  input  logic [7:0]   out_ready,
  output logic [2:0]   rr_ptr
);
  import demux_pkg::*;

  sel_t              dest;
  sel_t              rr_ptr_q, rr_ptr_d;
  logic              transfer;
  logic [NUM_CH-1:0] load_vec;
  logic [N-1:0]      slot_q [NUM_CH];

  // in_ready deliberately ignores in_valid and in_data to avoid a loop.
  always_comb begin
    dest     = auto ? rr_ptr_q : sel_t'(switch);
    in_ready = ~out_valid[dest] | out_ready[dest];
    transfer = in_valid & in_ready;
    rr_ptr_d = rr_ptr_q;
    if (transfer && auto) rr_ptr_d = rr_ptr_q + sel_t'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
      assign load_vec[gi] = transfer & (dest == sel_t'(gi));
      demux_slot #(.N(N)) u_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (load_vec[gi]),
        .d     (in_data),
        .ready (out_ready[gi]),
        .q     (slot_q[gi]),
        .valid (out_valid[gi])
      );
    end
  endgenerate

  assign out0   = slot_q[0];
  assign out1   = slot_q[1];
  assign out2   = slot_q[2];
  assign out3   = slot_q[3];
  assign out4   = slot_q[4];
  assign out5   = slot_q[5];
  assign out6   = slot_q[6];
  assign out7   = slot_q[7];
  assign rr_ptr = rr_ptr_q;
endmodule

// File: tb/tb_demux8_stream.sv
// Randomized and directed bench for demux8_stream against a behavioural model.
module tb_demux8_stream;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] switch = '0;
  logic       auto = 1'b0;
  logic [7:0] o [8];
  logic [7:0] out_valid;
  logic [7:0] out_ready = '0;
  logic [2:0] rr_ptr;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model: per-channel word/flag plus a round-robin integer.
  bit         mval [8];
  logic [7:0] mdat [8];
  int         mrr;
  int         landed [$];

  always #5 clk = ~clk;

  demux8_stream #(.N(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .switch(switch), .auto(auto),
    .out0(o[0]), .out1(o[1]), .out2(o[2]), .out3(o[3]),
    .out4(o[4]), .out5(o[5]), .out6(o[6]), .out7(o[7]),
    .out_valid(out_valid), .out_ready(out_ready), .rr_ptr(rr_ptr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = mval[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      mval[k] = 0;
      mdat[k] = '0;
    end
    mrr = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(model_valid()));
    check_eq({tag, ".rr_ptr"}, 32'(rr_ptr), 32'(mrr));
    for (int k = 0; k < 8; k++)
      check_eq($sformatf("%s.out%0d", tag, k), 32'(o[k]), 32'(mdat[k]));
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input string tag, input logic iv, input logic [7:0] id,
                      input logic [2:0] sw, input logic au, input logic [7:0] ordy);
    int  dst;
    bit  rdy;
    in_valid  = iv;
    in_data   = id;
    switch    = sw;
    auto      = au;
    out_ready = ordy;
    #1;
    dst = au ? mrr : int'(sw);
    rdy = !mval[dst] || ordy[dst];
    check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int k = 0; k < 8; k++)
        if (mval[k] && ordy[k]) mval[k] = 0;
      if (iv && rdy) begin
        mval[dst] = 1;
        mdat[dst] = id;
        landed.push_back(dst);
        if (au) mrr = (mrr + 1) % 8;
      end
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset.in_ready", 32'(in_ready), 32'd1);
    check_eq("reset.out_valid", 32'(out_valid), 32'h00);
    check_eq("reset.rr_ptr", 32'(rr_ptr), 32'd0);

    // Single explicit-select word, then probe readiness of full and empty channels.
    step("a5", 1, 8'hA5, 3'd3, 0, 8'h00);
    check_eq("a5.out3", 32'(o[3]), 32'hA5);
    check_eq("a5.valid", 32'(out_valid), 32'h08);
    step("probe3", 0, 8'h00, 3'd3, 0, 8'h00);
    step("probe2", 0, 8'h00, 3'd2, 0, 8'h00);

    // Round-robin burst with every consumer ready.
    landed.delete();
    for (int i = 0; i < 10; i++) step($sformatf("rr%0d", i), 1, 8'(i), 3'd0, 1, 8'hFF);
    check_eq("rr.end_ptr", 32'(rr_ptr), 32'd2);
    for (int i = 0; i < 10; i++)
      check_eq($sformatf("rr.order%0d", i), 32'(landed[i]), 32'(i % 8));

    // Head-of-line stall on channel 5, then load-while-draining.
    step("ch5.fill", 1, 8'h11, 3'd5, 0, 8'hFF);
    step("ch5.stall", 1, 8'h22, 3'd5, 0, 8'h00);
    check_eq("ch5.stall.data", 32'(o[5]), 32'h11);
    step("ch5.swap", 1, 8'h3C, 3'd5, 0, 8'h20);
    check_eq("ch5.swap.data", 32'(o[5]), 32'h3C);
    check_eq("ch5.swap.valid", 32'(out_valid[5]), 32'd1);

    // Round-robin destination blocked: pointer holds until the word lands.
    step("blk.fill", 1, 8'h77, 3'd2, 0, 8'h00);
    for (int i = 0; i < 3; i++) step($sformatf("blk%0d", i), 1, 8'h88, 3'd0, 1, 8'h00);
    check_eq("blk.hold", 32'(rr_ptr), 32'd2);
    step("blk.free", 1, 8'h88, 3'd0, 1, 8'h04);
    check_eq("blk.adv", 32'(rr_ptr), 32'd3);
    check_eq("blk.data", 32'(o[2]), 32'h88);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($sformatf("rnd%0d", i), ($urandom % 4) != 0, 8'($urandom), 3'($urandom),
           1'($urandom), 8'($urandom) & 8'($urandom));

    // Switch churn with no valid input.
    for (int i = 0; i < 8; i++) step($sformatf("idle%0d", i), 0, 8'hFF, 3'(i), 0, 8'h00);

    // Fill 0,2,7 then reset asynchronously between edges.
    step("f.drain", 0, 8'h00, 3'd0, 0, 8'hFF);
    step("f0", 1, 8'hC0, 3'd0, 0, 8'h00);
    step("f2", 1, 8'hC2, 3'd2, 0, 8'h00);
    step("f7", 1, 8'hC7, 3'd7, 0, 8'h00);
    step("fa", 1, 8'hCA, 3'd0, 1, 8'h00);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("arst.out_valid", 32'(out_valid), 32'h00);
    check_eq("arst.rr_ptr", 32'(rr_ptr), 32'd0);
    check_eq("arst.out7", 32'(o[7]), 32'h00);
    @(posedge clk);
    #1;
    // Transfer attempted while reset is held is lost.
    step("rst.xfer", 1, 8'h5A, 3'd1, 1, 8'h00);
    rst = 1'b0;
    step("post.rst", 1, 8'h5B, 3'd1, 1, 8'h00);
    check_eq("post.rst.out0", 32'(o[0]), 32'h5B);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
